// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg
// Shared header for the ALU arbiter slice. It holds the ALU op-code
// encoding used by the requesters and by the shared ALU, the arbiter FSM
// state encoding, and the requester index values.
// No ports; import with "import alu_arbiter_pkg::*;".
package alu_arbiter_pkg;

  // ALU op-code encoding. The arbiter passes these through without decoding;
  // they are listed here so requesters, the ALU and benches share one copy.
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Requester indices, as stored in the last-grant and current-owner registers.
  localparam logic REQ_0 = 1'b0;
  localparam logic REQ_1 = 1'b1;

endpackage

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one external combinational ALU between two requesters. A request
// is granted in IDLE (round robin on ties), its operands are latched and
// driven onto the ALU bus, the ALU result is captured one cycle later, and
// a one-cycle Valid pulse announces it. One operation per three cycles.
//
// Ports
//   CLK                    clock, all state updates on the rising edge
//   Reset                  synchronous active-high reset
//   Req0/Req1              requester asks for one ALU operation
//   Ctrl0/Ctrl1 [3:0]      requester ALU op code (passed through opaque)
//   A0/A1, B0/B1 [W-1:0]   requester operands
//   Gnt0/Gnt1              combinational: request accepted at this edge
//   Valid0/Valid1          one-cycle pulse, result on Result/Zero
//   Result0/Result1        registered ALU result per requester
//   Zero0/Zero1            registered ALU zero flag per requester
//   ALUBusA/ALUBusB/ALUCtrl  operand registers driving the shared ALU
//   ALUResult/ALUZero      combinational outputs of the shared ALU
//   Busy                   high whenever the FSM is not in IDLE
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Req0,
  input  logic             Req1,
  input  logic [3:0]       Ctrl0,
  input  logic [3:0]       Ctrl1,
  input  logic [WIDTH-1:0] A0,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] B0,
  input  logic [WIDTH-1:0] B1,
  output logic             Gnt0,
  output logic             Gnt1,
  output logic             Valid0,
  output logic             Valid1,
  output logic [WIDTH-1:0] Result0,
  output logic [WIDTH-1:0] Result1,
  output logic             Zero0,
  output logic             Zero1,
  output logic [WIDTH-1:0] ALUBusA,
  output logic [WIDTH-1:0] ALUBusB,
  output logic [3:0]       ALUCtrl,
  input  logic [WIDTH-1:0] ALUResult,
  input  logic             ALUZero,
  output logic             Busy
);

  state_t state;
  logic   last_gnt;
  logic   cur_idx;
  logic   pick0;
  logic   pick1;

  // Round-robin picker: only in IDLE and never while Reset is high. On a tie
  // the requester that did not win last time is chosen.
  always_comb begin
    pick0 = 1'b0;
    pick1 = 1'b0;
    if (state == IDLE && !Reset) begin
      if (Req0 && Req1) begin
        if (last_gnt == REQ_1) begin
          pick0 = 1'b1;
        end else begin
          pick1 = 1'b1;
        end
      end else begin
        pick0 = Req0;
        pick1 = Req1;
      end
    end
  end

  assign Gnt0 = pick0;
  assign Gnt1 = pick1;

  // Single FSM block. The operand registers double as the ALU bus drivers
  // and keep their values after the operation completes; results are held
  // per requester until that requester's next result.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state    <= IDLE;
      last_gnt <= REQ_1;
      cur_idx  <= REQ_0;
      ALUCtrl  <= '0;
      ALUBusA  <= '0;
      ALUBusB  <= '0;
      Result0  <= '0;
      Result1  <= '0;
      Zero0    <= 1'b0;
      Zero1    <= 1'b0;
      Valid0   <= 1'b0;
      Valid1   <= 1'b0;
      Busy     <= 1'b0;
    end else begin
      Valid0 <= 1'b0;
      Valid1 <= 1'b0;
      case (state)
        IDLE: begin
          if (pick0 || pick1) begin
            cur_idx  <= pick1 ? REQ_1 : REQ_0;
            last_gnt <= pick1 ? REQ_1 : REQ_0;
            ALUCtrl  <= pick1 ? Ctrl1 : Ctrl0;
            ALUBusA  <= pick1 ? A1 : A0;
            ALUBusB  <= pick1 ? B1 : B0;
            state    <= EXEC;
            Busy     <= 1'b1;
          end
        end
        EXEC: begin
          if (cur_idx == REQ_0) begin
            Result0 <= ALUResult;
            Zero0   <= ALUZero;
            Valid0  <= 1'b1;
          end else begin
            Result1 <= ALUResult;
            Zero1   <= ALUZero;
            Valid1  <= 1'b1;
          end
          state <= RESP;
        end
        RESP: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
// Bench for alu_arbiter. Provides the shared ALU, a cycle-level behavioural
// model of the arbiter that is compared against the DUT on every falling
// edge, a few directed scenarios with literal expectations, and a
// randomized phase.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int W = 32;

  logic         CLK;
  logic         Reset;
  logic         Req0, Req1;
  logic [3:0]   Ctrl0, Ctrl1;
  logic [W-1:0] A0, A1, B0, B1;
  logic         Gnt0, Gnt1, Valid0, Valid1, Zero0, Zero1, Busy;
  logic [W-1:0] Result0, Result1, ALUBusA, ALUBusB, ALUResult;
  logic [3:0]   ALUCtrl;
  logic         ALUZero;

  int tests_run    = 0;
  int tests_failed = 0;

  alu_arbiter #(.WIDTH(W)) dut (
    .CLK(CLK), .Reset(Reset),
    .Req0(Req0), .Req1(Req1), .Ctrl0(Ctrl0), .Ctrl1(Ctrl1),
    .A0(A0), .A1(A1), .B0(B0), .B1(B1),
    .Gnt0(Gnt0), .Gnt1(Gnt1), .Valid0(Valid0), .Valid1(Valid1),
    .Result0(Result0), .Result1(Result1), .Zero0(Zero0), .Zero1(Zero1),
    .ALUBusA(ALUBusA), .ALUBusB(ALUBusB), .ALUCtrl(ALUCtrl),
    .ALUResult(ALUResult), .ALUZero(ALUZero), .Busy(Busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // The shared ALU that sits beside the arbiter.
  function automatic logic [W-1:0] alu_fn(logic [3:0] c, logic [W-1:0] a, logic [W-1:0] b);
    case (c)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_NOR: return ~(a | b);
      ALU_SLT: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return a ^ b;
    endcase
  endfunction

  assign ALUResult = alu_fn(ALUCtrl, ALUBusA, ALUBusB);
  assign ALUZero   = (ALUResult == '0);

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r0, input logic [3:0] c0, input logic [W-1:0] a0,
                               input logic [W-1:0] b0, input logic r1, input logic [3:0] c1,
                               input logic [W-1:0] a1, input logic [W-1:0] b1);
    Req0 = r0; Ctrl0 = c0; A0 = a0; B0 = b0;
    Req1 = r1; Ctrl1 = c1; A1 = a1; B1 = b1;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  // phase counts cycles since the grant: 0 = waiting, 1 = operands on bus,
  // 2 = result reported.
  bit           m_live = 1'b0;
  int           m_phase;
  bit           m_last;
  bit           m_idx;
  logic [3:0]   m_c;
  logic [W-1:0] m_a, m_b;
  logic [W-1:0] m_res [2];
  bit           m_zero [2];

  function automatic bit model_gnt(int i);
    bit want [2];
    want[0] = Req0;
    want[1] = Req1;
    if (!m_live || Reset || m_phase != 0 || !want[i]) return 1'b0;
    if (want[1-i]) return (i != int'(m_last));
    return 1'b1;
  endfunction

  always @(posedge CLK) begin
    if (Reset) begin
      m_live = 1'b1; m_phase = 0; m_last = 1'b1; m_idx = 1'b0;
      m_c = '0; m_a = '0; m_b = '0;
      m_res[0] = '0; m_res[1] = '0; m_zero[0] = 1'b0; m_zero[1] = 1'b0;
    end else if (m_live) begin
      if (m_phase == 0) begin
        if (model_gnt(0) || model_gnt(1)) begin
          m_idx  = model_gnt(1);
          m_c    = m_idx ? Ctrl1 : Ctrl0;
          m_a    = m_idx ? A1 : A0;
          m_b    = m_idx ? B1 : B0;
          m_last = m_idx;
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        m_res[m_idx]  = alu_fn(m_c, m_a, m_b);
        m_zero[m_idx] = (m_res[m_idx] == '0);
        m_phase = 2;
      end else begin
        m_phase = 0;
      end
    end
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    if (m_live) begin
      checkOutput("Gnt0",    {31'd0, Gnt0},   {31'd0, model_gnt(0)});
      checkOutput("Gnt1",    {31'd0, Gnt1},   {31'd0, model_gnt(1)});
      checkOutput("Valid0",  {31'd0, Valid0}, {31'd0, (m_phase == 2 && !m_idx)});
      checkOutput("Valid1",  {31'd0, Valid1}, {31'd0, (m_phase == 2 && m_idx)});
      checkOutput("Busy",    {31'd0, Busy},   {31'd0, (m_phase != 0)});
      checkOutput("Result0", Result0, m_res[0]);
      checkOutput("Result1", Result1, m_res[1]);
      checkOutput("Zero0",   {31'd0, Zero0},  {31'd0, m_zero[0]});
      checkOutput("Zero1",   {31'd0, Zero1},  {31'd0, m_zero[1]});
      checkOutput("ALUBusA", ALUBusA, m_a);
      checkOutput("ALUBusB", ALUBusB, m_b);
      checkOutput("ALUCtrl", {28'd0, ALUCtrl}, {28'd0, m_c});
    end
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    Reset = 1'b1;
    applyStimulus(1'b0, 4'd0, '0, '0, 1'b0, 4'd0, '0, '0);
    tick();
    tick();
    @(negedge CLK);
    checkOutput("rst_busy",    {31'd0, Busy}, 32'd0);
    checkOutput("rst_result0", Result0, 32'd0);
    checkOutput("rst_gnt0",    {31'd0, Gnt0}, 32'd0);
    tick();
    Reset = 1'b0;

    // Single requester ADD 5+7.
    applyStimulus(1'b1, ALU_ADD, 32'd5, 32'd7, 1'b0, 4'd0, '0, '0);
    @(negedge CLK);
    checkOutput("add_gnt0", {31'd0, Gnt0}, 32'd1);
    tick();
    Req0 = 1'b0;
    tick();
    @(negedge CLK);
    checkOutput("add_valid0",  {31'd0, Valid0}, 32'd1);
    checkOutput("add_result0", Result0, 32'd12);
    checkOutput("add_zero0",   {31'd0, Zero0}, 32'd0);
    checkOutput("add_result1", Result1, 32'd0);
    tick();

    // Both held from reset with SUB: alternating grants every three cycles.
    Reset = 1'b1;
    applyStimulus(1'b1, ALU_SUB, 32'd9, 32'd9, 1'b1, ALU_SUB, 32'd10, 32'd3);
    tick();
    tick();
    Reset = 1'b0;
    for (int c = 0; c < 18; c++) begin
      @(negedge CLK);
      checkOutput("rr_gnt0", {31'd0, Gnt0}, {31'd0, (c % 3 == 0) && ((c / 3) % 2 == 0)});
      checkOutput("rr_gnt1", {31'd0, Gnt1}, {31'd0, (c % 3 == 0) && ((c / 3) % 2 == 1)});
      checkOutput("rr_one_gnt", {31'd0, Gnt0 & Gnt1}, 32'd0);
      if (c == 2) begin
        checkOutput("sub_valid0",  {31'd0, Valid0}, 32'd1);
        checkOutput("sub_result0", Result0, 32'd0);
        checkOutput("sub_zero0",   {31'd0, Zero0}, 32'd1);
      end
      if (c == 5) begin
        checkOutput("sub_valid1",  {31'd0, Valid1}, 32'd1);
        checkOutput("sub_result1", Result1, 32'd7);
        checkOutput("sub_zero1",   {31'd0, Zero1}, 32'd0);
      end
      tick();
    end
    applyStimulus(1'b0, 4'd0, '0, '0, 1'b0, 4'd0, '0, '0);
    tick();

    // Req1 raised only during a requester-0 EXEC, then dropped: not served.
    applyStimulus(1'b1, ALU_ADD, 32'd1, 32'd2, 1'b0, ALU_ADD, 32'd3, 32'd4);
    tick();
    Req0 = 1'b0;
    Req1 = 1'b1;
    @(negedge CLK);
    checkOutput("drop_gnt1_exec", {31'd0, Gnt1}, 32'd0);
    tick();
    Req1 = 1'b0;
    @(negedge CLK);
    checkOutput("drop_valid1_resp", {31'd0, Valid1}, 32'd0);
    tick();
    @(negedge CLK);
    checkOutput("drop_gnt1_idle", {31'd0, Gnt1}, 32'd0);
    tick();
    tick();

    // OR operation: bus carries the latched operands, not the live inputs.
    applyStimulus(1'b1, ALU_OR, 32'hF0F0_0000, 32'h0000_0F0F, 1'b0, 4'd0, '0, '0);
    @(negedge CLK);
    checkOutput("or_gnt0", {31'd0, Gnt0}, 32'd1);
    tick();
    applyStimulus(1'b0, ALU_ADD, 32'h1234_5678, 32'h1111_1111, 1'b0, 4'd0, '0, '0);
    @(negedge CLK);
    checkOutput("or_busa",  ALUBusA, 32'hF0F0_0000);
    checkOutput("or_busb",  ALUBusB, 32'h0000_0F0F);
    checkOutput("or_ctrl",  {28'd0, ALUCtrl}, {28'd0, ALU_OR});
    tick();
    @(negedge CLK);
    checkOutput("or_result0", Result0, 32'hF0F0_0F0F);
    tick();
    @(negedge CLK);
    checkOutput("or_busa_persist", ALUBusA, 32'hF0F0_0000);
    tick();

    // Reset while in EXEC with Req0 still active: aborted, no Valid.
    applyStimulus(1'b1, ALU_ADD, 32'd100, 32'd200, 1'b0, 4'd0, '0, '0);
    tick();
    Reset = 1'b1;
    @(negedge CLK);
    checkOutput("abort_busy_exec", {31'd0, Busy}, 32'd1);
    checkOutput("abort_gnt_rst",   {31'd0, Gnt0}, 32'd0);
    tick();
    Reset = 1'b0;
    Req0 = 1'b0;
    @(negedge CLK);
    checkOutput("abort_busy",    {31'd0, Busy}, 32'd0);
    checkOutput("abort_valid0",  {31'd0, Valid0}, 32'd0);
    checkOutput("abort_result0", Result0, 32'd0);
    checkOutput("abort_busa",    ALUBusA, 32'd0);
    tick();
    @(negedge CLK);
    checkOutput("abort_valid0_later", {31'd0, Valid0}, 32'd0);
    tick();

    // Randomized traffic, checked by the model process.
    for (int n = 0; n < 600; n++) begin
      Reset = ($urandom_range(0, 59) == 0);
      Req0  = $urandom_range(0, 2) != 0;
      Req1  = $urandom_range(0, 2) != 0;
      Ctrl0 = 4'($urandom);
      Ctrl1 = 4'($urandom);
      A0 = ($urandom_range(0, 3) == 0) ? B0 : $urandom;
      B0 = $urandom;
      A1 = $urandom;
      B1 = ($urandom_range(0, 3) == 0) ? A1 : $urandom;
      tick();
    end
    Reset = 1'b0;
    applyStimulus(1'b0, 4'd0, '0, '0, 1'b0, 4'd0, '0, '0);
    tick();
    tick();
    tick();
    @(negedge CLK);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
